rv_decode_stage: RTL and testbench

- Registered, handshaked instruction-decode stage for the RV32I/RV64I core. Sits between fetch and execute.
- Splits the instruction into fields and generates the full sign-extended XLEN immediate for every format.
- Produces the datapath control bundle and flags illegal encodings.
- Uses a valid/ready handshake with a one-entry skid buffer, so fetch never sees a combinational ready path from execute.

---
 rtl/rv_decode_stage_if.sv | 56 +++++
 rtl/rv_decode_stage.sv | 278 +++++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// ---------------------------------------------------------------------------
// rv_decode_stage_if
// Fetch-side and execute-side signal bundle of the instruction-decode stage.
//
//   in_valid_i / in_ready_o / instr_i / pc_i : fetch -> decode handshake
//   out_valid_o / out_ready_i                : decode -> execute handshake
//   pc_o .. muldiv_o                         : decoded bundle to execute
//
// Modports:
//   slave  - the decode stage itself
//   master - the environment around it (fetch + execute side)
// ---------------------------------------------------------------------------
interface rv_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [PC_W-1:0] pc_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic [PC_W-1:0] pc_o;
    logic [6:0]      opcode_o;
    logic [2:0]      func3_o;
    logic [6:0]      func7_o;
    logic [4:0]      rd_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [XLEN-1:0] imm_o;
    logic            reg_wr_o;
    logic            sel_a_o;
    logic            sel_b_o;
    logic            rd_en_o;
    logic            wr_en_o;
    logic [1:0]      wb_sel_o;
    logic            br_o;
    logic            jump_o;
    logic            illegal_o;
    logic            muldiv_o;

    modport slave (
        input  in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, opcode_o, func3_o, func7_o,
               rd_o, rs1_o, rs2_o, imm_o, reg_wr_o, sel_a_o, sel_b_o,
               rd_en_o, wr_en_o, wb_sel_o, br_o, jump_o, illegal_o, muldiv_o
    );

    modport master (
        output in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, opcode_o, func3_o, func7_o,
               rd_o, rs1_o, rs2_o, imm_o, reg_wr_o, sel_a_o, sel_b_o,
               rd_en_o, wr_en_o, wb_sel_o, br_o, jump_o, illegal_o, muldiv_o
    );
endinterface

// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// rv_decode_stage
// Registered, handshaked RV32I/RV64I instruction-decode stage between fetch
// and execute. The instruction is decoded combinationally on the way in, and
// the decoded bundle is held in an output register backed by a one-entry
// skid buffer, so in_ready_o depends only on stage state (never on
// out_ready_i).
//
// Ports:
//   clk      core clock
//   rst      synchronous active-high reset
//   flush_i  discard every held entry and any input presented this cycle
//   bus      rv_decode_stage_if.slave (fetch handshake, execute handshake,
//            decoded fields / immediate / control bundle)
//
// Parameters:
//   XLEN  datapath and immediate width (32 or 64)
//   PC_W  width of the PC carried alongside the instruction
//
// Build option:
//   RV_DEC_M_EXT_EN  when defined, OP with func7=0x01 (M extension) is legal
//                    and raises muldiv_o; otherwise it is illegal and
//                    muldiv_o stays 0.
// ---------------------------------------------------------------------------
module rv_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    rv_decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam bit IS_RV64 = (XLEN == 64);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            reg_wr;
        logic            sel_a;
        logic            sel_b;
        logic            rd_en;
        logic            wr_en;
        logic [1:0]      wb_sel;
        logic            br;
        logic            jump;
        logic            illegal;
        logic            muldiv;
    } dec_t;

    dec_t        dec_next;
    dec_t        out_reg;
    dec_t        skid_reg;
    logic        out_valid_reg;
    logic        skid_valid_reg;

    logic [31:0] ins;
    logic [31:0] imm32;
    logic        illegal;
    logic        muldiv;

    // -----------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // -----------------------------------------------------------------------
    assign ins = bus.instr_i;

    always_comb begin
        dec_next        = '0;
        imm32           = '0;
        illegal         = 1'b0;
        muldiv          = 1'b0;
        dec_next.pc     = bus.pc_i;
        dec_next.opcode = ins[6:0];

        case (ins[6:0])
            OPC_OP: begin
                dec_next.rd     = ins[11:7];
                dec_next.func3  = ins[14:12];
                dec_next.rs1    = ins[19:15];
                dec_next.rs2    = ins[24:20];
                dec_next.func7  = ins[31:25];
                dec_next.reg_wr = 1'b1;
                dec_next.sel_a  = 1'b1;
                dec_next.wb_sel = 2'b01;
                case (ins[31:25])
                    7'h00: ;
                    // Only SUB and SRA use the alternate func7
                    7'h20: illegal = !((ins[14:12] == 3'd0) || (ins[14:12] == 3'd5));
`ifdef RV_DEC_M_EXT_EN
                    7'h01: muldiv = 1'b1;
`else
                    7'h01: illegal = 1'b1;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_next.rd     = ins[11:7];
                dec_next.func3  = ins[14:12];
                dec_next.rs1    = ins[19:15];
                imm32           = {{20{ins[31]}}, ins[31:20]};
                dec_next.reg_wr = 1'b1;
                dec_next.sel_a  = 1'b1;
                dec_next.sel_b  = 1'b1;
                dec_next.wb_sel = 2'b01;
            end
            OPC_LOAD: begin
                dec_next.rd     = ins[11:7];
                dec_next.func3  = ins[14:12];
                dec_next.rs1    = ins[19:15];
                imm32           = {{20{ins[31]}}, ins[31:20]};
                dec_next.reg_wr = 1'b1;
                dec_next.sel_a  = 1'b1;
                dec_next.sel_b  = 1'b1;
                dec_next.rd_en  = 1'b1;
                dec_next.wb_sel = 2'b10;
                // LD/LWU exist only on RV64
                if (IS_RV64)
                    illegal = (ins[14:12] == 3'd7);
                else
                    illegal = (ins[14:12] == 3'd3) || (ins[14:12] >= 3'd6);
            end
            OPC_STORE: begin
                dec_next.func3  = ins[14:12];
                dec_next.rs1    = ins[19:15];
                dec_next.rs2    = ins[24:20];
                imm32           = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                dec_next.sel_a  = 1'b1;
                dec_next.sel_b  = 1'b1;
                dec_next.wr_en  = 1'b1;
                dec_next.wb_sel = 2'b01;
                illegal         = IS_RV64 ? (ins[14:12] >= 3'd4) : (ins[14:12] >= 3'd3);
            end
            OPC_BRANCH: begin
                dec_next.func3  = ins[14:12];
                dec_next.rs1    = ins[19:15];
                dec_next.rs2    = ins[24:20];
                imm32           = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                dec_next.sel_b  = 1'b1;
                dec_next.wb_sel = 2'b01;
                dec_next.br     = 1'b1;
                illegal         = (ins[14:12] == 3'd2) || (ins[14:12] == 3'd3);
            end
            OPC_JAL: begin
                dec_next.rd     = ins[11:7];
                imm32           = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                dec_next.reg_wr = 1'b1;
                dec_next.sel_b  = 1'b1;
                dec_next.wb_sel = 2'b00;
                dec_next.jump   = 1'b1;
            end
            OPC_JALR: begin
                dec_next.rd     = ins[11:7];
                dec_next.func3  = ins[14:12];
                dec_next.rs1    = ins[19:15];
                imm32           = {{20{ins[31]}}, ins[31:20]};
                dec_next.reg_wr = 1'b1;
                dec_next.sel_a  = 1'b1;
                dec_next.sel_b  = 1'b1;
                dec_next.wb_sel = 2'b00;
                dec_next.jump   = 1'b1;
                illegal         = (ins[14:12] != 3'd0);
            end
            OPC_LUI: begin
                dec_next.rd     = ins[11:7];
                imm32           = {ins[31:12], 12'b0};
                dec_next.reg_wr = 1'b1;
                dec_next.sel_a  = 1'b1;
                dec_next.sel_b  = 1'b1;
                dec_next.wb_sel = 2'b11;
            end
            OPC_AUIPC: begin
                dec_next.rd     = ins[11:7];
                imm32           = {ins[31:12], 12'b0};
                dec_next.reg_wr = 1'b1;
                dec_next.sel_b  = 1'b1;
                dec_next.wb_sel = 2'b01;
            end
            default: begin
                // Unknown format: pass raw fields so the trap handler sees them
                dec_next.rd    = ins[11:7];
                dec_next.func3 = ins[14:12];
                dec_next.rs1   = ins[19:15];
                dec_next.rs2   = ins[24:20];
                dec_next.func7 = ins[31:25];
                illegal        = 1'b1;
            end
        endcase

        if (ins[1:0] != 2'b11)
            illegal = 1'b1;

        dec_next.imm     = XLEN'($signed(imm32));
        dec_next.illegal = illegal;
        dec_next.muldiv  = muldiv & ~illegal;

        // Illegal entries still flow so execute can trap, but must not
        // produce any architectural side effect.
        if (illegal) begin
            dec_next.reg_wr = 1'b0;
            dec_next.rd_en  = 1'b0;
            dec_next.wr_en  = 1'b0;
            dec_next.br     = 1'b0;
            dec_next.jump   = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output register + one-entry skid buffer
    // -----------------------------------------------------------------------
    logic in_fire;
    logic out_free;

    assign bus.in_ready_o = !skid_valid_reg && !rst;
    assign in_fire        = bus.in_valid_i && !skid_valid_reg;
    // Output register can take a new entry this edge
    assign out_free       = !out_valid_reg || bus.out_ready_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_reg        <= '0;
            skid_reg       <= '0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                // in_ready was low, so nothing new can arrive this edge
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (in_fire) begin
                out_reg       <= dec_next;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (in_fire) begin
            skid_reg       <= dec_next;
            skid_valid_reg <= 1'b1;
        end
    end

    assign bus.out_valid_o = out_valid_reg;
    assign bus.pc_o        = out_reg.pc;
    assign bus.opcode_o    = out_reg.opcode;
    assign bus.func3_o     = out_reg.func3;
    assign bus.func7_o     = out_reg.func7;
    assign bus.rd_o        = out_reg.rd;
    assign bus.rs1_o       = out_reg.rs1;
    assign bus.rs2_o       = out_reg.rs2;
    assign bus.imm_o       = out_reg.imm;
    assign bus.reg_wr_o    = out_reg.reg_wr;
    assign bus.sel_a_o     = out_reg.sel_a;
    assign bus.sel_b_o     = out_reg.sel_b;
    assign bus.rd_en_o     = out_reg.rd_en;
    assign bus.wr_en_o     = out_reg.wr_en;
    assign bus.wb_sel_o    = out_reg.wb_sel;
    assign bus.br_o        = out_reg.br;
    assign bus.jump_o      = out_reg.jump;
    assign bus.illegal_o   = out_reg.illegal;
    assign bus.muldiv_o    = out_reg.muldiv;
endmodule

// File: tb/tb_rv_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_rv_decode_stage
// Directed-vector bench for rv_decode_stage (XLEN=32). Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Honors RV_DEC_M_EXT_EN for the expected result of the M-extension vector.
// ---------------------------------------------------------------------------
module tb_rv_decode_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    rv_decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

    rv_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    // {reg_wr, sel_a, sel_b, rd_en, wr_en, wb_sel[1:0], br, jump, illegal}
    function automatic logic [9:0] ctrl_obs();
        return {bus.reg_wr_o, bus.sel_a_o, bus.sel_b_o, bus.rd_en_o, bus.wr_en_o,
                bus.wb_sel_o, bus.br_o, bus.jump_o, bus.illegal_o};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [9:0]  ctrl;
        logic        md;
    } vec_t;

    vec_t vq[$];

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid_i = v;
        bus.instr_i    = ins;
        bus.pc_i       = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.instr_i     = '0;
        bus.pc_i        = '0;
        bus.out_ready_i = 1'b0;

        // ---------------- reset ----------------
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
            check("rst_in_ready",  64'(bus.in_ready_o),  64'd0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("post_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("post_rst_imm",       64'(bus.imm_o),       64'd0);
        check("post_rst_ctrl",      64'(ctrl_obs()),      64'd0);

        // ---------------- single addi ----------------
        tick();
        bus.out_ready_i = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h100);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        $display("addi x1,x0,-1 pc=0x100");
        check("addi_valid",  64'(bus.out_valid_o), 64'd1);
        check("addi_rd",     64'(bus.rd_o),        64'd1);
        check("addi_imm",    64'(bus.imm_o),       64'hFFFFFFFF);
        check("addi_reg_wr", 64'(bus.reg_wr_o),    64'd1);
        check("addi_sel_b",  64'(bus.sel_b_o),     64'd1);
        check("addi_wb_sel", 64'(bus.wb_sel_o),    64'd1);
        check("addi_pc",     64'(bus.pc_o),        64'h100);
        tick();
        @(negedge clk);
        check("addi_drained", 64'(bus.out_valid_o), 64'd0);

        // ---------------- streaming directed vectors ----------------
        vq.push_back('{32'hFFF00093, 32'hFFFFFFFF, 10'b1_1_1_0_0_01_0_0_0, 1'b0}); // addi -1
        vq.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 10'b0_0_1_0_0_01_1_0_0, 1'b0}); // beq -4
        vq.push_back('{32'h001000EF, 32'h00000800, 10'b1_0_1_0_0_00_0_1_0, 1'b0}); // jal +2048
        vq.push_back('{32'h123452B7, 32'h12345000, 10'b1_1_1_0_0_11_0_0_0, 1'b0}); // lui
        vq.push_back('{32'h00007003, 32'h00000000, 10'b0_1_1_0_0_10_0_0_1, 1'b0}); // load f3=7
`ifdef RV_DEC_M_EXT_EN
        vq.push_back('{32'h02000033, 32'h00000000, 10'b1_1_0_0_0_01_0_0_0, 1'b1}); // mul
`else
        vq.push_back('{32'h02000033, 32'h00000000, 10'b0_1_0_0_0_01_0_0_1, 1'b0}); // mul (illegal)
`endif
        vq.push_back('{32'h0020A423, 32'h00000008, 10'b0_1_1_0_1_01_0_0_0, 1'b0}); // sw x2,8(x1)
        vq.push_back('{32'h402081B3, 32'h00000000, 10'b1_1_0_0_0_01_0_0_0, 1'b0}); // sub
        vq.push_back('{32'h00000000, 32'h00000000, 10'b0_0_0_0_0_00_0_0_1, 1'b0}); // instr[1:0]=00
        vq.push_back('{32'hFFFFF097, 32'hFFFFF000, 10'b1_0_1_0_0_01_0_0_0, 1'b0}); // auipc
        vq.push_back('{32'h000090E7, 32'h00000000, 10'b0_1_1_0_0_00_0_0_1, 1'b0}); // jalr f3=1
        vq.push_back('{32'h40001033, 32'h00000000, 10'b0_1_0_0_0_01_0_0_1, 1'b0}); // f7=0x20 f3=1
        vq.push_back('{32'h0040A103, 32'h00000004, 10'b1_1_1_1_0_10_0_0_0, 1'b0}); // lw x2,4(x1)

        drive(1'b1, vq[0].instr, 32'h200);
        for (int i = 0; i < vq.size(); i++) begin
            tick();
            if (i + 1 < vq.size())
                drive(1'b1, vq[i+1].instr, 32'h200 + 32'(4 * (i + 1)));
            else
                drive(1'b0, 32'h0, 32'h0);
            @(negedge clk);
            $display("vec %0d instr=0x%08h pc=0x%0h imm=0x%08h", i, vq[i].instr,
                     32'h200 + 32'(4 * i), bus.imm_o);
            check("vec_valid",  64'(bus.out_valid_o), 64'd1);
            check("vec_pc",     64'(bus.pc_o),        64'(32'h200 + 32'(4 * i)));
            check("vec_imm",    64'(bus.imm_o),       64'(vq[i].imm));
            check("vec_ctrl",   64'(ctrl_obs()),      64'(vq[i].ctrl));
            check("vec_muldiv", 64'(bus.muldiv_o),    64'(vq[i].md));
        end
        tick();

        // ---------------- backpressure + skid ----------------
        bus.out_ready_i = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h300);   // A -> output reg
        tick();
        drive(1'b1, 32'h123452B7, 32'h304);   // B -> skid
        tick();
        drive(1'b1, 32'h0020A423, 32'h308);   // C held by fetch
        @(negedge clk);
        $display("backpressure: A in output, B in skid");
        check("bp_in_ready",  64'(bus.in_ready_o),  64'd0);
        check("bp_out_valid", 64'(bus.out_valid_o), 64'd1);
        check("bp_pc_hold",   64'(bus.pc_o),        64'h300);
        tick();
        @(negedge clk);
        check("bp_pc_hold2",  64'(bus.pc_o),        64'h300);
        check("bp_imm_hold",  64'(bus.imm_o),       64'hFFFFFFFF);
        check("bp_in_ready2", 64'(bus.in_ready_o),  64'd0);
        tick();
        bus.out_ready_i = 1'b1;
        tick();                               // A consumed, B from skid
        @(negedge clk);
        $display("backpressure: release, B delivered");
        check("bp_b_pc",       64'(bus.pc_o),        64'h304);
        check("bp_b_imm",      64'(bus.imm_o),       64'h12345000);
        check("bp_b_valid",    64'(bus.out_valid_o), 64'd1);
        check("bp_b_in_ready", 64'(bus.in_ready_o),  64'd1);
        tick();                               // B consumed, C accepted
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        $display("backpressure: C delivered");
        check("bp_c_pc",    64'(bus.pc_o),        64'h308);
        check("bp_c_imm",   64'(bus.imm_o),       64'h8);
        check("bp_c_valid", 64'(bus.out_valid_o), 64'd1);
        tick();
        @(negedge clk);
        check("bp_drained", 64'(bus.out_valid_o), 64'd0);

        // ---------------- flush with output + skid full ----------------
        tick();
        bus.out_ready_i = 1'b0;
        drive(1'b1, 32'h123452B7, 32'h400);   // D
        tick();
        drive(1'b1, 32'h0040A103, 32'h404);   // E -> skid
        tick();
        drive(1'b1, 32'h0020A423, 32'h408);   // F with flush
        flush = 1'b1;
        @(negedge clk);
        check("fl_pre_valid", 64'(bus.out_valid_o), 64'd1);
        check("fl_pre_ready", 64'(bus.in_ready_o),  64'd0);
        tick();
        flush = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h500);   // G
        @(negedge clk);
        $display("flush with output and skid full");
        check("fl_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("fl_in_ready",  64'(bus.in_ready_o),  64'd1);
        tick();                               // G accepted
        drive(1'b1, 32'h123452B7, 32'h504);   // H would go to skid, flushed
        flush = 1'b1;
        @(negedge clk);
        check("fl_g_valid", 64'(bus.out_valid_o), 64'd1);
        check("fl_g_pc",    64'(bus.pc_o),        64'h500);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        $display("flush with output full and input pending");
        check("fl2_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("fl2_in_ready",  64'(bus.in_ready_o),  64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("fl_no_ghost", 64'(bus.out_valid_o), 64'd0);
        end

        // flush with empty stage: simultaneous input is dropped
        tick();
        drive(1'b1, 32'hFFF00093, 32'h600);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        $display("flush with empty stage and input pending");
        check("fl3_out_valid", 64'(bus.out_valid_o), 64'd0);
        tick();
        @(negedge clk);
        check("fl3_no_ghost", 64'(bus.out_valid_o), 64'd0);

        // ---------------- reset during operation ----------------
        bus.out_ready_i = 1'b0;
        drive(1'b1, 32'h123452B7, 32'h700);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        $display("reset while holding an entry");
        check("mid_rst_held",     64'(bus.out_valid_o), 64'd1);
        check("mid_rst_in_ready", 64'(bus.in_ready_o),  64'd0);
        tick();
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("mid_rst_imm",       64'(bus.imm_o),       64'd0);
        check("mid_rst_pc",        64'(bus.pc_o),        64'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("mid_rst_ready_after", 64'(bus.in_ready_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
